// File: rtl/trace_collector.sv
// trace_collector: buffers control-flow trace items coming out of the trace
// filter in a small first-word-fall-through FIFO. Each stored item carries the
// number of instructions that were not stored since the previous stored item,
// so the consumer can reconstruct how much execution it did not see. A full
// FIFO never stalls the core; lost items are counted instead.
module trace_collector #(
  parameter int PC_WIDTH   = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_WIDTH  = 16,
  parameter int OVF_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          clear,
  input  logic                          instr_valid,
  input  logic [PC_WIDTH-1:0]           pc,
  input  logic [31:0]                   instr,
  input  logic                          drop_instr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PC_WIDTH-1:0]           out_pc,
  output logic [31:0]                   out_instr,
  output logic [GAP_WIDTH-1:0]          out_gap,
  output logic                          out_gap_sat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [OVF_WIDTH-1:0]          overflow_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [GAP_WIDTH-1:0] GAP_MAX = '1;
  localparam logic [OVF_WIDTH-1:0] OVF_MAX = '1;
  localparam logic [CW-1:0]        CNT_FULL = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [PC_WIDTH-1:0]  pc;
    logic [31:0]          instr;
    logic [GAP_WIDTH-1:0] gap;
    logic                 gap_sat;
  } item_t;

  item_t                mem [FIFO_DEPTH];
  item_t                head;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [GAP_WIDTH-1:0] gap;
  logic                 gap_sat;

  logic flush, accept, kept, dropped, full, pop, push, lost, gap_inc;

  // Event decode. A flush wins over everything, so pop/push are masked by it
  // to keep the data array from being written during a flush.
  always_comb begin
    flush   = rst || clear;
    accept  = instr_valid && en;
    kept    = accept && !drop_instr;
    dropped = accept && drop_instr;
    full    = (count == CNT_FULL);
    pop     = out_valid && out_ready && !flush;
    // a pop in the same cycle frees the slot the new item needs
    push    = kept && (!full || pop) && !flush;
    lost    = kept && full && !pop && !flush;
    // a lost item is folded into the gap so the next stored item shows it
    gap_inc = dropped || lost;
  end

  // Occupancy and pointers; pointers wrap naturally since depth is a power of 2.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Data array; entries need no reset because fifo_count guards them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: pc, instr: instr, gap: gap, gap_sat: gap_sat};
  end

  // Gap tracker: counts unstored instructions, saturating and latching gap_sat
  // on the cycle it reaches all-ones.
  always_ff @(posedge clk) begin
    if (flush || push) begin
      gap     <= '0;
      gap_sat <= 1'b0;
    end else if (gap_inc && gap != GAP_MAX) begin
      gap <= gap + GAP_WIDTH'(1);
      if (gap == GAP_MAX - GAP_WIDTH'(1)) gap_sat <= 1'b1;
    end
  end

  // Saturating count of kept items lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (flush)                              overflow_count <= '0;
    else if (lost && overflow_count != OVF_MAX) overflow_count <= overflow_count + OVF_WIDTH'(1);
  end

  // First-word-fall-through head presentation.
  always_comb begin
    head        = mem[rd_ptr];
    out_valid   = (count != '0);
    out_pc      = head.pc;
    out_instr   = head.instr;
    out_gap     = head.gap;
    out_gap_sat = head.gap_sat;
    fifo_count  = count;
  end

endmodule

// File: tb/tb_trace_collector.sv
// Scoreboard bench for trace_collector: the driver applies directed and
// random stimulus, updates a queue-based reference model and pushes expected
// items; an independent monitor pops/compares on every output handshake.
module tb_trace_collector;

  localparam int PCW = 64;
  localparam int DEPTH = 8;
  localparam int GW = 4;
  localparam int OW = 4;
  localparam int GMAX = 15;
  localparam int OMAX = 15;

  logic          clk, rst, en, clear, instr_valid, drop_instr, out_ready;
  logic [PCW-1:0] pc, out_pc;
  logic [31:0]   instr, out_instr;
  logic          out_valid, out_gap_sat;
  logic [GW-1:0] out_gap;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [OW-1:0] overflow_count;

  trace_collector #(.PC_WIDTH(PCW), .FIFO_DEPTH(DEPTH), .GAP_WIDTH(GW), .OVF_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .instr_valid(instr_valid),
    .pc(pc), .instr(instr), .drop_instr(drop_instr), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .out_gap(out_gap),
    .out_gap_sat(out_gap_sat), .fifo_count(fifo_count), .overflow_count(overflow_count)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    int          gap;
    bit          sat;
  } item_t;

  item_t exp_q[$];
  int    exp_cnt = 0, exp_ovf = 0;   // model state after the last edge
  int    m_gap = 0;
  bit    m_sat = 0;
  bit    mon_en = 0;
  int    n_chk = 0, n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic bump();
    if (m_gap < GMAX) m_gap++;
    m_sat = (m_gap == GMAX);
  endtask

  // One cycle of stimulus; the model is advanced by the rules for that edge.
  task automatic step(input bit iv, input bit dr, input bit e, input bit rdy,
                      input bit clr, input bit rs, input logic [63:0] p, input logic [31:0] ins);
    bit pop, kept, room, push;
    int n_cnt, n_ovf;
    instr_valid = iv; drop_instr = dr; en = e; out_ready = rdy;
    clear = clr; rst = rs; pc = p; instr = ins;
    pop = (exp_cnt > 0) && rdy;
    if (clr || rs) begin
      exp_q.delete();
      m_gap = 0; m_sat = 0; n_cnt = 0; n_ovf = 0;
    end else begin
      kept  = iv && e && !dr;
      room  = (exp_cnt < DEPTH) || pop;
      push  = kept && room;
      n_ovf = exp_ovf;
      if (push) begin
        exp_q.push_back('{pc: p, instr: ins, gap: m_gap, sat: m_sat});
        m_gap = 0; m_sat = 0;
      end else if (kept) begin
        if (n_ovf < OMAX) n_ovf++;
        bump();
      end else if (iv && e && dr) begin
        bump();
      end
      n_cnt = exp_cnt + (push ? 1 : 0) - (pop ? 1 : 0);
    end
    @(posedge clk); #1;
    exp_cnt = n_cnt; exp_ovf = n_ovf;
  endtask

  task automatic keep(input logic [63:0] p, input logic [31:0] ins, input bit rdy);
    step(1, 0, 1, rdy, 0, 0, p, ins);
  endtask
  task automatic dropi(input bit rdy);
    step(1, 1, 1, rdy, 0, 0, 64'h0, 32'h13);
  endtask
  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, rdy, 0, 0, 64'h0, 32'h0);
  endtask

  // Monitor: state checks every cycle, item checks on every accepted pop.
  always @(negedge clk) begin
    item_t it;
    if (mon_en) begin
      chk("out_valid", {63'h0, out_valid}, {63'h0, exp_cnt != 0});
      chk("fifo_count", 64'(fifo_count), 64'(exp_cnt));
      chk("overflow_count", 64'(overflow_count), 64'(exp_ovf));
      if (out_valid && out_ready && !clear && !rst) begin
        if (exp_q.size() == 0) chk("pop_with_empty_model", 64'h1, 64'h0);
        else begin
          it = exp_q.pop_front();
          chk("out_pc", out_pc, it.pc);
          chk("out_instr", 64'(out_instr), 64'(it.instr));
          chk("out_gap", 64'(out_gap), 64'(it.gap));
          chk("out_gap_sat", {63'h0, out_gap_sat}, {63'h0, it.sat});
        end
      end
    end
  end

  initial begin
    rst = 1; clear = 0; en = 0; instr_valid = 0; drop_instr = 0;
    out_ready = 0; pc = '0; instr = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 0; mon_en = 1;

    // three filtered instructions, then a return
    for (int i = 0; i < 3; i++) dropi(0);
    keep(64'h8000_0010, 32'h0000_8067, 0);
    chk("t1_gap", 64'(out_gap), 64'd3);
    chk("t1_pc", out_pc, 64'h8000_0010);
    chk("t1_instr", 64'(out_instr), 64'h8067);
    chk("t1_sat", {63'h0, out_gap_sat}, 64'h0);
    chk("t1_count", 64'(fifo_count), 64'd1);
    idle(1, 2);

    // ten kept with no consumer: two are lost, then drain and check the gap
    for (int i = 1; i <= 10; i++) keep(64'h1000 + 64'(i * 4), 32'h6F + 32'(i << 12), 0);
    chk("t2_count", 64'(fifo_count), 64'd8);
    chk("t2_ovf", 64'(overflow_count), 64'd2);
    idle(1, 9);
    keep(64'h2000, 32'h0000_0063, 0);
    chk("t2_gap", 64'(out_gap), 64'd2);
    idle(1, 2);

    // full FIFO: push and pop in the same cycle takes no overflow
    for (int i = 0; i < 8; i++) keep(64'h3000 + 64'(i), 32'hE7, 0);
    keep(64'h3100, 32'h1E7, 1);
    chk("t3_count", 64'(fifo_count), 64'd8);
    chk("t3_ovf", 64'(overflow_count), 64'd2);
    idle(1, 10);

    // gap saturation, then a back-to-back item starts from zero
    for (int i = 0; i < 20; i++) dropi(0);
    keep(64'h4000, 32'h1050_0073, 0);
    chk("t4_gap", 64'(out_gap), 64'd15);
    chk("t4_sat", {63'h0, out_gap_sat}, 64'h1);
    keep(64'h4004, 32'h63, 1);
    idle(1, 2);

    // disabled: nothing accepted, FIFO still drains
    keep(64'h5000, 32'h67, 0); keep(64'h5004, 32'h67, 0);
    dropi(0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 0, 0, 64'h0, 32'h13);
    step(1, 0, 0, 1, 0, 0, 64'h5100, 32'h67);
    step(1, 0, 0, 1, 0, 0, 64'h5104, 32'h67);
    keep(64'h5200, 32'h6F, 1);
    chk("t5_gap", 64'(out_gap), 64'd1);
    idle(1, 2);

    // clear with same-cycle push and pop, then repeat via rst
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) keep(64'h6000 + 64'(i), 32'h67, 0);
      for (int i = 0; i < 7; i++) dropi(0);
      step(1, 0, 1, 1, k == 0, k == 1, 64'h6100, 32'h67);
      chk("t6_valid", {63'h0, out_valid}, 64'h0);
      chk("t6_count", 64'(fifo_count), 64'd0);
      chk("t6_ovf", 64'(overflow_count), 64'd0);
      keep(64'h6200, 32'h67, 0);
      chk("t6_gap", 64'(out_gap), 64'd0);
      idle(1, 2);
    end

    // random phases with varying consumer pressure
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 600; i++) begin
        step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 8) != 0,
             ($urandom % 4) < ph, ($urandom % 250) == 0, ($urandom % 500) == 0,
             {$urandom, $urandom}, $urandom);
      end
    end
    idle(1, DEPTH + 2);
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
